// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and byte helpers for the UART echo path
package uart_pkg;

    localparam int MODE_ECHO = 0;
    localparam int MODE_CASE = 1;
    localparam int MODE_INC  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } echo_state_t;

    localparam logic [7:0] ASCII_UC_LO = 8'h41;
    localparam logic [7:0] ASCII_UC_HI = 8'h5A;
    localparam logic [7:0] ASCII_LC_LO = 8'h61;
    localparam logic [7:0] ASCII_LC_HI = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    function automatic logic is_alpha(input logic [7:0] b);
        return ((b >= ASCII_UC_LO) && (b <= ASCII_UC_HI)) ||
               ((b >= ASCII_LC_LO) && (b <= ASCII_LC_HI));
    endfunction

    function automatic logic [7:0] case_swap(input logic [7:0] b);
        return is_alpha(b) ? (b ^ ASCII_CASE_BIT) : b;
    endfunction

endpackage

// File: rtl/sync_fifo_m.sv
// rtl/sync_fifo_m.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo_m #(
    parameter int DATAW     = 8,
    parameter int DEPTHLOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATAW-1:0]     wdata,
    output logic [DATAW-1:0]     rdata,
    output logic [DEPTHLOG2:0]   level,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 1 << DEPTHLOG2;

    logic [DATAW-1:0]     mem_q [DEPTH];
    logic [DEPTHLOG2-1:0] wr_ptr_q;
    logic [DEPTHLOG2-1:0] rd_ptr_q;
    logic [DEPTHLOG2:0]   level_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (DEPTHLOG2+1)'(DEPTH));
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + DEPTHLOG2'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTHLOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (DEPTHLOG2+1)'(1);
                2'b01:   level_q <= level_q - (DEPTHLOG2+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset so it can map onto block or distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_echo_buf.sv
// rtl/uart_echo_buf.sv - buffered echo engine: FIFO, transmit handshake FSM, transform, overflow count
module uart_echo_buf
    import uart_pkg::*;
#(
    parameter int DATAW     = 8,
    parameter int DEPTHLOG2 = 4,
    parameter int MODE      = 0,
    parameter int OVFW      = 8,
    parameter int BUSYTMO   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bytercvd,
    input  logic [DATAW-1:0]     q,
    input  logic                 txbusy,
    input  logic                 en,
    input  logic                 clr_ovf,
    output logic                 load,
    output logic [DATAW-1:0]     d,
    output logic [DEPTHLOG2:0]   level,
    output logic                 overflow,
    output logic [OVFW-1:0]      ovf_count
);

    localparam int TMOW = (BUSYTMO < 2) ? 1 : $clog2(BUSYTMO + 1);

    echo_state_t          state_q;
    logic                 load_q;
    logic [DATAW-1:0]     d_q;
    logic [TMOW-1:0]      tmo_q;
    logic                 overflow_q;
    logic [OVFW-1:0]      ovf_count_q;

    logic [DATAW-1:0]     fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 drop;

    function automatic logic [DATAW-1:0] xform(input logic [DATAW-1:0] b);
        logic [DATAW-1:0] r;
        r = b;
        if (MODE == MODE_INC) begin
            r = b + DATAW'(1);
        end else if ((MODE == MODE_CASE) && (DATAW == 8)) begin
            r = DATAW'(case_swap(8'(b)));
        end
        return r;
    endfunction

    assign pop  = (state_q == IDLE) && en && !fifo_empty;
    assign drop = bytercvd && fifo_full && !pop;

    sync_fifo_m #(
        .DATAW     (DATAW),
        .DEPTHLOG2 (DEPTHLOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bytercvd),
        .pop   (pop),
        .wdata (q),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            d_q     <= '0;
            tmo_q   <= '0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        d_q     <= xform(fifo_rdata);
                        load_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    tmo_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                // Give up on a transmitter that never reports busy after a load.
                WAIT_BUSY: begin
                    if (txbusy) begin
                        state_q <= WAIT_IDLE;
                    end else if (tmo_q == TMOW'(BUSYTMO - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMOW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (!txbusy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            ovf_count_q <= '0;
        end else if (clr_ovf) begin
            overflow_q  <= 1'b0;
            ovf_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (ovf_count_q != '1) begin
                ovf_count_q <= ovf_count_q + OVFW'(1);
            end
        end
    end

    assign load      = load_q;
    assign d         = d_q;
    assign overflow  = overflow_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_uart_echo_buf.sv
// tb/tb_uart_echo_buf.sv - scoreboard bench for uart_echo_buf in echo, case-swap and increment modes
module tb_uart_echo_buf;

    logic       clk = 1'b0;
    logic       rst_n, bytercvd, txbusy, en, clr_ovf;
    logic [7:0] q;

    logic [2:0] ld;
    logic [7:0] d0, d1, d2;
    logic [2:0] lvl0, lvl1, lvl2;
    logic [2:0] ovf;
    logic [7:0] oc0, oc1, oc2;

    always #5 clk = ~clk;

    uart_echo_buf #(.DATAW(8), .DEPTHLOG2(2), .MODE(0), .OVFW(8), .BUSYTMO(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bytercvd(bytercvd), .q(q), .txbusy(txbusy), .en(en),
        .clr_ovf(clr_ovf), .load(ld[0]), .d(d0), .level(lvl0), .overflow(ovf[0]), .ovf_count(oc0));
    uart_echo_buf #(.DATAW(8), .DEPTHLOG2(2), .MODE(1), .OVFW(8), .BUSYTMO(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bytercvd(bytercvd), .q(q), .txbusy(txbusy), .en(en),
        .clr_ovf(clr_ovf), .load(ld[1]), .d(d1), .level(lvl1), .overflow(ovf[1]), .ovf_count(oc1));
    uart_echo_buf #(.DATAW(8), .DEPTHLOG2(2), .MODE(2), .OVFW(8), .BUSYTMO(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .bytercvd(bytercvd), .q(q), .txbusy(txbusy), .en(en),
        .clr_ovf(clr_ovf), .load(ld[2]), .d(d2), .level(lvl2), .overflow(ovf[2]), .ovf_count(oc2));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int load_cnt0 = 0;
    int peak = 0;
    int busy_len = 0;
    bit kill = 1'b0;
    bit ld_prev = 1'b0;
    int lt[$];
    logic [7:0] exp0[$], exp1[$], exp2[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] m_case(input logic [7:0] b);
        if (((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A)))
            return b ^ 8'h20;
        return b;
    endfunction

    // Monitor: every load on any instance pops that instance's scoreboard.
    initial forever begin
        @(negedge clk);
        ld_prev = ld[0];
        if (int'(lvl0) > peak) peak = int'(lvl0);
        if (ld[0] === 1'b1) begin
            load_cnt0++;
            lt.push_back(cyc);
            if (exp0.size() == 0) chk("unexpected_load0", 1, 0);
            else chk("d_mode0", d0, exp0.pop_front());
        end
        if (ld[1] === 1'b1) begin
            if (exp1.size() == 0) chk("unexpected_load1", 1, 0);
            else chk("d_mode1", d1, exp1.pop_front());
        end
        if (ld[2] === 1'b1) begin
            if (exp2.size() == 0) chk("unexpected_load2", 1, 0);
            else chk("d_mode2", d2, exp2.pop_front());
        end
    end

    // Transmitter model: busy rises the cycle after load and stays up busy_len cycles.
    initial begin
        int cnt;
        cnt = 0;
        txbusy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (kill) begin
                cnt = 0;
                kill = 1'b0;
            end else if (ld_prev) cnt = busy_len;
            else if (cnt > 0) cnt--;
            txbusy = (cnt > 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_x(input logic [7:0] b, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input bit acc, output int t);
        t = cyc;
        bytercvd = 1'b1;
        q = b;
        if (acc) begin
            exp0.push_back(e0);
            exp1.push_back(e1);
            exp2.push_back(e2);
        end
        step();
        bytercvd = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input bit acc, output int t);
        push_x(b, b, m_case(b), b + 8'd1, acc, t);
    endtask

    task automatic wait_loads(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (load_cnt0 < n && k < budget) begin
            step();
            k++;
        end
        chk(nm, load_cnt0, n);
    endtask

    logic [7:0] tv_in [5] = '{8'h61, 8'h5A, 8'h31, 8'hFF, 8'h10};
    logic [7:0] tv_m1 [5] = '{8'h41, 8'h7A, 8'h31, 8'hFF, 8'h10};
    logic [7:0] tv_m2 [5] = '{8'h62, 8'h5B, 8'h32, 8'h00, 8'h11};

    initial begin
        int t, base, n0;
        rst_n = 1'b0; bytercvd = 1'b0; q = 8'h00; en = 1'b0; clr_ovf = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_load", ld, 3'b000);
        chk("rst_d", {d0, d1, d2}, 24'h0);
        chk("rst_level", lvl0, 0);
        chk("rst_ovf", {ovf, oc0}, 0);
        step();
        rst_n = 1'b1;
        step();

        // Single byte: level 1 at t+1, load with d at t+2.
        en = 1'b1; busy_len = 20;
        push(8'h55, 1'b1, t);
        @(negedge clk);
        chk("single_lvl_t1", lvl0, 1);
        chk("single_noload_t1", ld[0], 0);
        step();
        @(negedge clk);
        chk("single_load_t2", ld[0], 1);
        chk("single_lvl_t2", lvl0, 0);
        repeat (30) step();
        chk("single_count", load_cnt0, 1);
        chk("single_latency", lt[0] - t, 2);

        // Burst of five against a 50-cycle transmitter.
        busy_len = 50; peak = 0; base = load_cnt0;
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1, t);
        wait_loads(base + 5, 400, "burst_loads");
        chk("burst_peak", peak, 4);
        chk("burst_ovf", ovf, 0);
        for (int i = 1; i < 5; i++) chk("burst_gap", lt[base + i] - lt[base + i - 1], 53);
        repeat (60) step();

        // Overflow with paused drain, then clear colliding with a drop.
        en = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i), i < 4, t);
        @(negedge clk);
        chk("ovf_level", lvl0, 4);
        chk("ovf_flag", ovf, 3'b111);
        chk("ovf_count", oc0, 2);
        step();
        clr_ovf = 1'b1;
        push(8'hEE, 1'b0, t);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("clr_flag", ovf, 3'b000);
        chk("clr_count", {oc0, oc1, oc2}, 24'h0);
        chk("clr_level", lvl0, 4);
        step();
        busy_len = 2; base = load_cnt0; en = 1'b1;
        wait_loads(base + 4, 200, "drain_loads");
        repeat (20) step();
        chk("drain_only4", load_cnt0, base + 4);
        chk("drain_level", lvl0, 0);

        // Transform vectors across the three instances.
        base = load_cnt0;
        for (int i = 0; i < 5; i++) push_x(tv_in[i], tv_in[i], tv_m1[i], tv_m2[i], 1'b1, t);
        wait_loads(base + 5, 200, "xform_loads");
        repeat (10) step();

        // Transmitter never raises busy: timeout returns FSM to IDLE.
        busy_len = 0; base = load_cnt0;
        push(8'h21, 1'b1, t);
        push(8'h42, 1'b1, t);
        wait_loads(base + 2, 100, "tmo_loads");
        chk("tmo_gap", lt[base + 1] - lt[base], 6);
        repeat (10) step();

        // Reset while waiting on a busy transmitter with bytes queued.
        busy_len = 50; base = load_cnt0;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b1, t);
        repeat (8) step();
        @(negedge clk);
        chk("mid_level", lvl0, 3);
        chk("mid_loads", load_cnt0, base + 1);
        chk("mid_pending", exp0.size(), 3);
        exp0.delete(); exp1.delete(); exp2.delete();
        step();
        rst_n = 1'b0; kill = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_load", ld, 3'b000);
        chk("mid_rst_d", {d0, d1, d2}, 24'h0);
        chk("mid_rst_level", {lvl0, lvl1, lvl2}, 9'h0);
        step();
        busy_len = 5; base = load_cnt0;
        push(8'h3C, 1'b1, t);
        wait_loads(base + 1, 20, "post_rst_load");
        chk("post_rst_latency", lt[base] - t, 2);
        repeat (20) step();
        chk("final_sb0", exp0.size(), 0);
        chk("final_sb12", exp1.size() + exp2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
